// File: rtl/ram_pkg.sv
// rtl/ram_pkg.sv - shared defaults and FSM encoding for the RAM read initiator
package ram_pkg;

  localparam int RAM_ADDR_SIZE = 4;
  localparam int RAM_DATA_SIZE = 8;
  localparam int RAM_DEPTH     = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } rd_state_t;

endpackage

// File: rtl/dual_port_ram_reader_if.sv
// rtl/dual_port_ram_reader_if.sv - valid/ready word stream leaving the reader
interface dual_port_ram_reader_if
  import ram_pkg::*;
#(
  parameter int DATA_SIZE = RAM_DATA_SIZE
);

  logic [DATA_SIZE-1:0] m_data;
  logic                 m_valid;
  logic                 m_ready;
  logic                 m_last;

  modport master (output m_data, output m_valid, output m_last, input m_ready);
  modport slave  (input m_data, input m_valid, input m_last, output m_ready);

endinterface

// File: rtl/ram_rd_skid.sv
// rtl/ram_rd_skid.sv - 2-entry FIFO absorbing RAM returns while the stream stalls
module ram_rd_skid #(
  parameter int DATA_SIZE = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 push,
  input  logic [DATA_SIZE-1:0] push_data,
  input  logic                 pop,
  output logic [1:0]           count,
  output logic [DATA_SIZE-1:0] head
);

  logic [DATA_SIZE-1:0] mem [2];
  logic                 wr_ptr;
  logic                 rd_ptr;

  // push and pop on one entry touch different slots, so ordering holds
  always_ff @(posedge clk) begin
    if (rst) begin
      mem[0] <= '0;
      mem[1] <= '0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= ~wr_ptr;
      end
      if (pop) begin
        rd_ptr <= ~rd_ptr;
      end
      count <= count + 2'(push) - 2'(pop);
    end
  end

  assign head = mem[rd_ptr];

endmodule

// File: rtl/dual_port_ram_reader.sv
// rtl/dual_port_ram_reader.sv - burst read initiator streaming RAM words with backpressure
module dual_port_ram_reader
  import ram_pkg::*;
#(
  parameter int ADDR_SIZE = RAM_ADDR_SIZE,
  parameter int DATA_SIZE = RAM_DATA_SIZE,
  parameter int DEPTH     = RAM_DEPTH
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [ADDR_SIZE-1:0] base_addr,
  input  logic [ADDR_SIZE:0]   length,
  output logic                 busy,
  output logic                 done,
  output logic                 ram_cs,
  output logic                 ram_re,
  output logic                 ram_oe,
  output logic [ADDR_SIZE-1:0] ram_rd_address,
  input  logic [DATA_SIZE-1:0] ram_data_out,
  dual_port_ram_reader_if.master m
);

  rd_state_t            state, state_nxt;
  logic [ADDR_SIZE-1:0] ptr;
  logic [ADDR_SIZE-1:0] ptr_inc;
  logic [ADDR_SIZE:0]   remaining;
  logic [ADDR_SIZE:0]   beats;
  logic                 inflight;
  logic                 issue;
  logic                 pop;
  logic [1:0]           fifo_count;
  logic [2:0]           occupancy;
  logic [DATA_SIZE-1:0] fifo_head;

  assign pop       = m.m_valid & m.m_ready;
  assign occupancy = 3'(fifo_count) + 3'(inflight) - 3'(pop);
  assign ptr_inc   = (ptr == ADDR_SIZE'(DEPTH - 1)) ? '0 : ptr + 1'b1;

  always_comb begin
    state_nxt = state;
    issue     = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          state_nxt = (length != '0) ? ISSUE : DONE;
        end
      end
      ISSUE: begin
        if (remaining == '0) begin
          state_nxt = DRAIN;
        end else if (occupancy < 3'd2) begin
          // an issue is only allowed when its return is guaranteed a FIFO slot
          issue = 1'b1;
        end
      end
      DRAIN: begin
        if (!inflight && fifo_count == 2'd0 && beats == '0) begin
          state_nxt = DONE;
        end
      end
      DONE: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      ptr       <= '0;
      remaining <= '0;
      beats     <= '0;
      inflight  <= 1'b0;
      done      <= 1'b0;
    end else begin
      state    <= state_nxt;
      inflight <= issue;
      done     <= (state == DONE);
      if (state == IDLE && start) begin
        ptr       <= base_addr;
        remaining <= length;
        beats     <= length;
      end else begin
        if (issue) begin
          ptr       <= ptr_inc;
          remaining <= remaining - 1'b1;
        end
        if (pop) begin
          beats <= beats - 1'b1;
        end
      end
    end
  end

  ram_rd_skid #(.DATA_SIZE(DATA_SIZE)) u_skid (
    .clk       (clk),
    .rst       (rst),
    .push      (inflight),
    .push_data (ram_data_out),
    .pop       (pop),
    .count     (fifo_count),
    .head      (fifo_head)
  );

  // RAM stays enabled through stalls so data_out never floats
  assign busy           = (state == ISSUE) || (state == DRAIN);
  assign ram_cs         = busy;
  assign ram_re         = busy;
  assign ram_oe         = busy;
  assign ram_rd_address = ptr;

  assign m.m_valid = (fifo_count != 2'd0);
  assign m.m_data  = fifo_head;
  assign m.m_last  = m.m_valid && (beats == (ADDR_SIZE+1)'(1));

endmodule

// File: tb/tb_dual_port_ram_reader.sv
// tb/tb_dual_port_ram_reader.sv - randomized bench with behavioural RAM and stream model
module tb_dual_port_ram_reader;
  import ram_pkg::*;

  localparam int AW    = 4;
  localparam int DW    = 8;
  localparam int DEPTH = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [AW-1:0] base_addr;
  logic [AW:0]   length;
  logic          busy, done, ram_cs, ram_re, ram_oe;
  logic [AW-1:0] ram_rd_address;
  logic [DW-1:0] ram_data_out = '0;

  dual_port_ram_reader_if #(.DATA_SIZE(DW)) s_if ();

  always #5 clk = ~clk;

  dual_port_ram_reader #(.ADDR_SIZE(AW), .DATA_SIZE(DW), .DEPTH(DEPTH)) dut (
    .clk            (clk),
    .rst            (rst),
    .start          (start),
    .base_addr      (base_addr),
    .length         (length),
    .busy           (busy),
    .done           (done),
    .ram_cs         (ram_cs),
    .ram_re         (ram_re),
    .ram_oe         (ram_oe),
    .ram_rd_address (ram_rd_address),
    .ram_data_out   (ram_data_out),
    .m              (s_if)
  );

  // behavioural RAM read port: one-cycle registered read
  logic [DW-1:0] mem [DEPTH];
  always @(posedge clk) begin
    if (ram_cs && ram_re && ram_oe) ram_data_out <= mem[ram_rd_address];
  end

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  logic [DW-1:0] exp_q [$];
  logic [DW-1:0] got_q [$];
  logic [AW-1:0] addr_q [$];
  int done_cnt, re_cnt, valid_cnt;
  int first_valid_cyc, first_pop_cyc, last_pop_cyc, done_cyc, start_cyc;
  int mode = 0;
  int tog_idx = 0;
  bit pat [6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
  bit stall_prev = 1'b0;
  logic [DW-1:0] prev_data;
  logic prev_last;
  logic [AW-1:0] last_addr;
  bit was_busy = 1'b0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // one clock: drive ready for the coming edge, then compare outputs to the model
  task automatic tick();
    @(negedge clk);
    cyc++;
    case (mode)
      0:       s_if.m_ready = 1'b1;
      1:       begin s_if.m_ready = pat[tog_idx % 6]; tog_idx++; end
      default: s_if.m_ready = 1'($urandom_range(0, 1));
    endcase
    if (stall_prev) begin
      check("stall_valid", int'(s_if.m_valid), 1);
      check("stall_data", int'(s_if.m_data), int'(prev_data));
      check("stall_last", int'(s_if.m_last), int'(prev_last));
    end
    if (s_if.m_valid) begin
      valid_cnt++;
      if (first_valid_cyc < 0) first_valid_cyc = cyc;
      if (s_if.m_ready) begin
        if (exp_q.size() == 0) begin
          check("extra_beat", 1, 0);
        end else begin
          check("beat_data", int'(s_if.m_data), int'(exp_q[0]));
          check("beat_last", int'(s_if.m_last), int'(exp_q.size() == 1));
          got_q.push_back(s_if.m_data);
          void'(exp_q.pop_front());
          if (first_pop_cyc < 0) first_pop_cyc = cyc;
          last_pop_cyc = cyc;
        end
      end
    end
    stall_prev = s_if.m_valid && !s_if.m_ready;
    prev_data  = s_if.m_data;
    prev_last  = s_if.m_last;
    if (done) begin
      done_cnt++;
      if (done_cyc < 0) done_cyc = cyc;
    end
    if (ram_re) re_cnt++;
    if (busy && (!was_busy || ram_rd_address != last_addr)) addr_q.push_back(ram_rd_address);
    last_addr = ram_rd_address;
    was_busy  = busy;
  endtask

  task automatic clear_model();
    exp_q.delete(); got_q.delete(); addr_q.delete();
    done_cnt = 0; re_cnt = 0; valid_cnt = 0;
    first_valid_cyc = -1; first_pop_cyc = -1; last_pop_cyc = -1; done_cyc = -1;
    stall_prev = 1'b0;
  endtask

  task automatic launch(input logic [AW-1:0] b, input int len);
    for (int i = 0; i < len; i++) exp_q.push_back(mem[(int'(b) + i) % DEPTH]);
    base_addr = b;
    length    = (AW+1)'(len);
    start     = 1'b1;
    start_cyc = cyc;
    tick();
    start = 1'b0;
  endtask

  task automatic run_burst(input logic [AW-1:0] b, input int len, input int md, input bit mid_start);
    mode = md;
    clear_model();
    launch(b, len);
    for (int i = 0; i < 400 && done_cnt == 0; i++) begin
      if (mid_start && i == 6) begin
        start = 1'b1; base_addr = b + 4'd5; length = 5'd2;
      end else begin
        start = 1'b0;
      end
      tick();
    end
    start = 1'b0;
    check("done_seen", done_cnt, 1);
    tick();
    tick();
    check("done_once", done_cnt, 1);
    check("all_delivered", exp_q.size(), 0);
    check("beat_count", got_q.size(), len);
    check("idle_after", int'(busy), 0);
    if (len > 0) check("first_valid_lat", first_valid_cyc - start_cyc, 3);
    if (len > 0 && md == 0) check("throughput", last_pop_cyc - first_pop_cyc, len - 1);
    if (len == 0) begin
      check("len0_no_re", re_cnt, 0);
      check("len0_no_valid", valid_cnt, 0);
      check("len0_done_lat", done_cyc - start_cyc, 2);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_busy"}, int'(busy), 0);
    check({tag, "_done"}, int'(done), 0);
    check({tag, "_cs"}, int'(ram_cs), 0);
    check({tag, "_re"}, int'(ram_re), 0);
    check({tag, "_oe"}, int'(ram_oe), 0);
    check({tag, "_addr"}, int'(ram_rd_address), 0);
    check({tag, "_valid"}, int'(s_if.m_valid), 0);
    check({tag, "_last"}, int'(s_if.m_last), 0);
    check({tag, "_data"}, int'(s_if.m_data), 0);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; base_addr = '0; length = '0; s_if.m_ready = 1'b0;
    for (int i = 0; i < DEPTH; i++) mem[i] = DW'($urandom);
    clear_model();
    tick();
    tick();
    check_all_zero("reset");
    rst = 1'b0;
    tick();

    // basic burst with literal expectations
    mem[3] = 8'hA0; mem[4] = 8'hA1; mem[5] = 8'hA2; mem[6] = 8'hA3;
    run_burst(4'd3, 4, 0, 1'b0);
    check("lit_b0", int'(got_q.size() > 0 ? got_q[0] : 8'h00), 8'hA0);
    check("lit_b3", int'(got_q.size() > 3 ? got_q[3] : 8'h00), 8'hA3);

    // address wrap
    mem[14] = 8'h11; mem[15] = 8'h22; mem[0] = 8'h33; mem[1] = 8'h44;
    run_burst(4'hE, 4, 0, 1'b0);
    check("wrap_addr0", int'(addr_q.size() > 0 ? addr_q[0] : 4'h5), 4'hE);
    check("wrap_addr1", int'(addr_q.size() > 1 ? addr_q[1] : 4'h5), 4'hF);
    check("wrap_addr2", int'(addr_q.size() > 2 ? addr_q[2] : 4'h5), 4'h0);
    check("wrap_addr3", int'(addr_q.size() > 3 ? addr_q[3] : 4'h5), 4'h1);
    check("wrap_d2", int'(got_q.size() > 2 ? got_q[2] : 8'h00), 8'h33);
    check("wrap_d3", int'(got_q.size() > 3 ? got_q[3] : 8'h00), 8'h44);

    run_burst(4'd5, 5, 1, 1'b0);
    run_burst(4'd7, 0, 0, 1'b0);

    for (int i = 0; i < DEPTH; i++) mem[i] = DW'($urandom);
    run_burst(4'd0, 16, 0, 1'b1);
    check("full_first", int'(got_q.size() > 0 ? got_q[0] : ~mem[0]), int'(mem[0]));
    check("full_last", int'(got_q.size() > 15 ? got_q[15] : ~mem[15]), int'(mem[15]));

    // reset in the middle of an 8-word burst
    mode = 0;
    clear_model();
    launch(4'd2, 8);
    for (int i = 0; i < 50 && got_q.size() < 2; i++) tick();
    check("pre_reset_beats", got_q.size(), 2);
    rst = 1'b1;
    tick();
    check_all_zero("midrst");
    rst = 1'b0;
    clear_model();
    tick();
    tick();
    check("post_rst_quiet", valid_cnt + re_cnt, 0);
    run_burst(4'd9, 3, 2, 1'b0);

    for (int n = 0; n < 8; n++) begin
      run_burst(AW'($urandom_range(0, DEPTH - 1)), int'($urandom_range(1, DEPTH)), 2, 1'b0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
